// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage of a 5-stage pipeline. A combinational ALU
//            (logic / shift / arithmetic groups) plus a 32-cycle restoring
//            divider that stalls the pipeline while it works and presents
//            quotient/remainder on the LO/HI write port for one cycle.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            aluop_i, alusel_i   - operation code and result group
//            reg1_i, reg2_i      - operands (reg1_i[4:0] is the shift amount)
//            wd_i, wreg_i        - destination address / write enable
//            annul_i             - pipeline flush, aborts a divide
//            wd_o, wreg_o, wdata_o - writeback info to EX/MEM
//            whilo_o, hi_o, lo_o - HI/LO write strobe and data
//            stallreq_o          - stall request while dividing
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter logic [7:0] OP_AND  = 8'h24,
    parameter logic [7:0] OP_OR   = 8'h25,
    parameter logic [7:0] OP_XOR  = 8'h26,
    parameter logic [7:0] OP_ADDU = 8'h21,
    parameter logic [7:0] OP_SUBU = 8'h23,
    parameter logic [7:0] OP_SLT  = 8'h2A,
    parameter logic [7:0] OP_SLL  = 8'h7C,
    parameter logic [7:0] OP_SRL  = 8'h02,
    parameter logic [7:0] OP_DIV  = 8'h1A,
    parameter logic [7:0] OP_DIVU = 8'h1B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd4;

    logic [1:0]  state_q,      state_d;
    logic [4:0]  cnt_q,        cnt_d;
    logic [31:0] dividend_q,   dividend_d;
    logic [31:0] divisor_q,    divisor_d;
    logic [31:0] quot_q,       quot_d;
    logic [31:0] rem_q,        rem_d;
    logic        neg_quot_q,   neg_quot_d;
    logic        neg_rem_q,    neg_rem_d;

    logic        w_is_div;
    logic        w_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic [32:0] w_trial;

    // ------------------------------------------------------------------
    // ALU: purely combinational, independent of the divider
    // ------------------------------------------------------------------
    always_comb begin
        wdata_o = 32'h0;
        case (alusel_i)
            SEL_LOGIC: begin
                if      (aluop_i == OP_AND) wdata_o = reg1_i & reg2_i;
                else if (aluop_i == OP_OR)  wdata_o = reg1_i | reg2_i;
                else if (aluop_i == OP_XOR) wdata_o = reg1_i ^ reg2_i;
            end
            SEL_SHIFT: begin
                if      (aluop_i == OP_SLL) wdata_o = reg2_i << reg1_i[4:0];
                else if (aluop_i == OP_SRL) wdata_o = reg2_i >> reg1_i[4:0];
            end
            SEL_ARITH: begin
                if      (aluop_i == OP_ADDU) wdata_o = reg1_i + reg2_i;
                else if (aluop_i == OP_SUBU) wdata_o = reg1_i - reg2_i;
                else if (aluop_i == OP_SLT)
                    wdata_o = ($signed(reg1_i) < $signed(reg2_i)) ? 32'h1 : 32'h0;
            end
            default: wdata_o = 32'h0;
        endcase
    end

    assign wd_o   = wd_i;
    assign wreg_o = wreg_i & ~stallreq_o;

    // ------------------------------------------------------------------
    // Divider operand preparation
    // ------------------------------------------------------------------
    assign w_is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign w_signed = (aluop_i == OP_DIV);
    // Signed divide runs on magnitudes; signs are reapplied in DONE.
    assign w_a_mag  = (w_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign w_b_mag  = (w_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

    // One restoring step: bring in the next dividend bit and try to subtract.
    // The partial remainder is always below the divisor, so 33 bits suffice
    // and bit 32 of the trial difference is the "borrow / restore" flag.
    assign w_shift = {rem_q, dividend_q[31]};
    assign w_trial = w_shift - {1'b0, divisor_q};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            dividend_q <= 32'h0;
            divisor_q  <= 32'h0;
            quot_q     <= 32'h0;
            rem_q      <= 32'h0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;

        if (annul_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_is_div) begin
                        if (reg2_i == 32'h0) begin
                            // Divide by zero: fixed result, no iteration
                            state_d    = S_DONE;
                            quot_d     = 32'hFFFF_FFFF;
                            rem_d      = reg1_i;
                            neg_quot_d = 1'b0;
                            neg_rem_d  = 1'b0;
                        end else begin
                            state_d    = S_BUSY;
                            cnt_d      = 5'd0;
                            dividend_d = w_a_mag;
                            divisor_d  = w_b_mag;
                            quot_d     = 32'h0;
                            rem_d      = 32'h0;
                            neg_quot_d = w_signed & (reg1_i[31] ^ reg2_i[31]);
                            neg_rem_d  = w_signed & reg1_i[31];
                        end
                    end
                end
                S_BUSY: begin
                    dividend_d = {dividend_q[30:0], 1'b0};
                    if (!w_trial[32]) begin
                        rem_d  = w_trial[31:0];
                        quot_d = {quot_q[30:0], 1'b1};
                    end else begin
                        rem_d  = w_shift[31:0];
                        quot_d = {quot_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        stallreq_o = 1'b0;
        whilo_o    = 1'b0;
        hi_o       = 32'h0;
        lo_o       = 32'h0;
        if (!annul_i) begin
            case (state_q)
                S_IDLE: stallreq_o = w_is_div;
                S_BUSY: stallreq_o = 1'b1;
                S_DONE: begin
                    whilo_o = 1'b1;
                    lo_o    = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
                    hi_o    = neg_rem_q  ? (~rem_q  + 32'd1) : rem_q;
                end
                default: stallreq_o = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters (name, default, meaning):
- OP_AND, 8'h24, bitwise AND
- OP_OR, 8'h25, bitwise OR
- OP_XOR, 8'h26, bitwise XOR
- OP_ADDU, 8'h21, add, modulo 2^32
- OP_SUBU, 8'h23, subtract, modulo 2^32
- OP_SLT, 8'h2A, signed set-less-than
- OP_SLL, 8'h7C, shift left logical
- OP_SRL, 8'h02, shift right logical
- OP_DIV, 8'h1A, signed divide
- OP_DIVU, 8'h1B, unsigned divide
REQ-002 Ports (name, direction, width, meaning); clock and reset are clk and rst; rst is synchronous, active-high:
- clk, in, 1, clock
- rst, in, 1, synchronous reset, active-high
- aluop_i, in, 8, operation from ID/EX register
- alusel_i, in, 3, result group: 0 NOP, 1 LOGIC, 2 SHIFT, 4 ARITH
- reg1_i, in, 32, operand A; for shifts, shift amount in [4:0]
- reg2_i, in, 32, operand B
- wd_i, in, 5, destination register address
- wreg_i, in, 1, register write enable
- annul_i, in, 1, pipeline flush; aborts divide
- wd_o, out, 5, destination to EX/MEM
- wreg_o, out, 1, write enable to EX/MEM
- wdata_o, out, 32, result
- whilo_o, out, 1, HI/LO write strobe
- hi_o, out, 32, HI result
- lo_o, out, 32, LO result
- stallreq_o, out, 1, request pipeline stall

Function
REQ-003 ALU path SHALL be combinational: wdata_o per alusel_i group (LOGIC: AND/OR/XOR; SHIFT: reg2_i shifted by reg1_i[4:0]; ARITH: ADDU/SUBU/SLT); any unlisted alusel_i/aluop_i gives 0.
REQ-004 SLT SHALL compare signed 32-bit and produce 32'h1 or 32'h0; ADDU/SUBU SHALL wrap with no overflow flag.
REQ-005 wd_o SHALL equal wd_i combinationally; wreg_o SHALL equal wreg_i except 0 while stallreq_o=1.
REQ-006 Divider FSM SHALL have states IDLE, BUSY, DONE.
REQ-007 IDLE + DIV/DIVU + annul_i=0, divisor nonzero: latch operands (magnitudes for DIV; quotient/remainder sign flags); 5-bit counter=0; go BUSY; stallreq_o=1 that cycle (cycle 0).
REQ-008 IDLE + DIV/DIVU with reg2_i=0: go DONE next cycle; result lo=32'hFFFFFFFF, hi=reg1_i; stallreq_o=1 in cycle 0.
REQ-009 BUSY SHALL perform one restoring shift-subtract step per cycle for 32 cycles (cycles 1..32, counter 0..31) with stallreq_o=1; after step 31 go DONE.
REQ-010 DONE (cycle 33 normal): stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder; next state IDLE unconditionally; the still-present divide op SHALL NOT restart.
REQ-011 Signed DIV: quotient negative iff operand signs differ; remainder takes dividend's sign; truncation toward zero; 32'h80000000 / -1 gives lo=32'h80000000, hi=0.
REQ-012 annul_i=1 in any state: next state IDLE, stallreq_o=0 that cycle, whilo_o=0; has priority over start/advance.
REQ-013 whilo_o SHALL be 1 only in DONE; hi_o/lo_o SHALL be 0 outside DONE.
REQ-014 Non-divide ops in IDLE SHALL leave FSM in IDLE with stallreq_o=0.

Reset
REQ-015 rst=1 SHALL force IDLE, counter 0, internal dividend/divisor/quotient/remainder registers 0 on the next edge; takes priority over annul_i and FSM.
REQ-016 Following reset: stallreq_o=0, whilo_o=0, hi_o=lo_o=0; wdata_o/wd_o/wreg_o follow inputs combinationally.
REQ-017 rst asserted mid-BUSY SHALL abort the divide; no whilo_o pulse ever produced for it.

Verification
REQ-018 alusel=1, OP_OR, reg1=0x0F0F0000, reg2=0x00FF00FF -> wdata_o=0x0FFF00FF same cycle; stallreq_o=0.
REQ-019 ARITH OP_SUBU 5-7 -> 0xFFFFFFFE; OP_SLT reg1=0xFFFFFFFF, reg2=1 -> 0x00000001.
REQ-020 OP_DIVU 100/7 held at inputs -> stallreq_o=1 for cycles 0..32, cycle 33 whilo_o=1, lo=14, hi=2, wreg_o=0 during stall.
REQ-021 OP_DIV 0xFFFFFFF9/2 -> cycle 33 lo=0xFFFFFFFD, hi=0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-022 OP_DIVU 9/0 -> cycle 0 stall, cycle 1 whilo_o=1, lo=0xFFFFFFFF, hi=9.
REQ-023 DIVU started, rst (or annul_i) pulsed at cycle 10 -> next cycle stallreq_o=0, no whilo_o pulse within 40 cycles with input NOP.
